// File: rtl/ff_registro_serie.sv
// Parallel-in, serial-out shift register with load handshake.
// A word accepted in IDLE is sent MSB first. Each bit is held for
// BIT_CYCLES clocks. A one-cycle done pulse follows the last bit.
module ff_registro_serie #(
    parameter int WIDTH      = 8,
    parameter int BIT_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] D,
    input  logic             load,
    output logic             ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             done
);

    // Each counter is wide enough to reach its last value and no wider.
    // BIT_CYCLES == 1 still gets a 1-bit counter, which stays at zero.
    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;

    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
    localparam logic [CW-1:0] CYC_LAST = CW'(BIT_CYCLES - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state_q,   state_d;
    logic [WIDTH-1:0] shreg_q,   shreg_d;
    logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
    logic [CW-1:0]    cyc_cnt_q, cyc_cnt_d;
    logic             done_q,    done_d;

    // State and datapath registers. Reset is asynchronous.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            cyc_cnt_q <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
            cyc_cnt_q <= cyc_cnt_d;
            done_q    <= done_d;
        end
    end

    // Next state: load in IDLE, then count and shift in SHIFT.
    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        cyc_cnt_d = cyc_cnt_q;
        done_d    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (load) begin
                    shreg_d   = D;
                    bit_cnt_d = '0;
                    cyc_cnt_d = '0;
                    state_d   = SHIFT;
                end
            end

            SHIFT: begin
                // load is ignored here, so D can change freely mid-word.
                if (cyc_cnt_q == CYC_LAST) begin
                    cyc_cnt_d = '0;
                    shreg_d   = {shreg_q[WIDTH-2:0], 1'b0};
                    if (bit_cnt_q == BIT_LAST) begin
                        bit_cnt_d = '0;
                        state_d   = IDLE;
                        done_d    = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end else begin
                    cyc_cnt_d = cyc_cnt_q + 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs come only from registered state. sout is forced to 0 while not valid.
    always_comb begin
        ready      = (state_q == IDLE);
        sout_valid = (state_q == SHIFT);
        sout       = (state_q == SHIFT) & shreg_q[WIDTH-1];
        done       = done_q;
    end

endmodule

// File: tb/tb_ff_registro_serie.sv
// Scoreboard bench for ff_registro_serie. Two instances are used:
// BIT_CYCLES=1 (index 0) and BIT_CYCLES=3 (index 1).
// The model expands every accepted word into per-cycle expected outputs.
// The monitor compares these against the DUT on each falling edge.
module tb_ff_registro_serie;

    typedef struct {
        int unsigned p;   // cycle index (posedges so far) the entry applies to
        bit          s;   // expected sout
        bit          v;   // expected sout_valid
        bit          d;   // expected done
    } exp_t;

    logic       clk;
    logic       rst;
    logic       end_req;
    logic [7:0] d_in [2];
    logic       ld   [2];
    logic       rdy  [2];
    logic       so   [2];
    logic       sv   [2];
    logic       dn   [2];

    int unsigned cnt;
    int unsigned free_at [2];
    exp_t        sb [2][$];
    int          n_checks;
    int          n_fail;

    ff_registro_serie #(.WIDTH(8), .BIT_CYCLES(1)) u_bc1 (
        .clk        (clk),
        .rst        (rst),
        .D          (d_in[0]),
        .load       (ld[0]),
        .ready      (rdy[0]),
        .sout       (so[0]),
        .sout_valid (sv[0]),
        .done       (dn[0])
    );

    ff_registro_serie #(.WIDTH(8), .BIT_CYCLES(3)) u_bc3 (
        .clk        (clk),
        .rst        (rst),
        .D          (d_in[1]),
        .load       (ld[1]),
        .ready      (rdy[1]),
        .sout       (so[1]),
        .sout_valid (sv[1]),
        .done       (dn[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input int i, input logic act, input logic expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s dut%0d cycle %0d: got %0b expected %0b", nm, i, cnt, act, expv);
        end
    endtask

    // Reference model. A word accepted at edge n sends bit k (MSB first)
    // during cycles n+k*BC .. n+(k+1)*BC-1. done follows in cycle n+8*BC.
    // The next load can be accepted at the edge after that.
    always @(posedge clk) begin
        cnt = cnt + 1;
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                sb[i].delete();
                free_at[i] = 0;
            end else if (ld[i] && cnt >= free_at[i]) begin
                int unsigned bc;
                logic [7:0]  w;
                exp_t        e;
                bc = (i == 0) ? 1 : 3;
                w  = d_in[i];
                for (int k = 0; k < 8; k++) begin
                    for (int c = 0; c < int'(bc); c++) begin
                        e.p = cnt + k * bc + c;
                        e.s = w[7 - k];
                        e.v = 1'b1;
                        e.d = 1'b0;
                        sb[i].push_back(e);
                    end
                end
                e.p = cnt + 8 * bc;
                e.s = 1'b0;
                e.v = 1'b0;
                e.d = 1'b1;
                sb[i].push_back(e);
                free_at[i] = cnt + 8 * bc + 1;
            end
        end
    end

    // Monitor: checks each cycle on the falling edge. It also checks shortly
    // after rst rises, and checks that the scoreboard is empty at the end.
    initial begin : monitor
        bit   finished;
        exp_t e;
        finished = 1'b0;
        forever begin
            @(negedge clk or posedge rst or posedge end_req);
            if (end_req && !finished) begin
                finished = 1'b1;
                for (int i = 0; i < 2; i++) begin
                    n_checks++;
                    if (sb[i].size() != 0) begin
                        n_fail++;
                        $display("FAIL drain dut%0d: got %0d pending entries expected 0", i, sb[i].size());
                    end
                end
            end else if (rst && clk) begin
                #1;
                for (int i = 0; i < 2; i++) begin
                    check("async_rst_ready", i, rdy[i], 1'b1);
                    check("async_rst_sout",  i, so[i],  1'b0);
                    check("async_rst_valid", i, sv[i],  1'b0);
                    check("async_rst_done",  i, dn[i],  1'b0);
                end
            end else if (!clk) begin
                for (int i = 0; i < 2; i++) begin
                    if (!rst && sb[i].size() > 0 && sb[i][0].p == cnt) begin
                        e = sb[i].pop_front();
                        check("sout",       i, so[i],  e.s);
                        check("sout_valid", i, sv[i],  e.v);
                        check("done",       i, dn[i],  e.d);
                        check("ready",      i, rdy[i], !e.v);
                    end else begin
                        check("idle_sout",  i, so[i],  1'b0);
                        check("idle_valid", i, sv[i],  1'b0);
                        check("idle_done",  i, dn[i],  1'b0);
                        check("idle_ready", i, rdy[i], 1'b1);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Raise rst between edges and hold it through the next rising edge.
    task automatic pulse_reset();
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic send(input int i, input logic [7:0] w);
        d_in[i] = w;
        ld[i]   = 1'b1;
        tick();
        ld[i]   = 1'b0;
    endtask

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        cnt        = 0;
        free_at[0] = 0;
        free_at[1] = 0;
        rst        = 1'b0;
        end_req    = 1'b0;
        ld[0]      = 1'b0;
        ld[1]      = 1'b0;
        d_in[0]    = '0;
        d_in[1]    = '0;

        // Power-on reset, raised while clk is high.
        @(posedge clk);
        #1 rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (2) tick();

        // Basic word.
        send(0, 8'hA5);
        repeat (12) tick();

        // Slow bits.
        send(1, 8'h81);
        repeat (28) tick();

        // Load during SHIFT is ignored.
        send(0, 8'h0F);
        repeat (3) tick();
        d_in[0] = 8'hFF;
        ld[0]   = 1'b1;
        tick();
        ld[0]   = 1'b0;
        repeat (10) tick();

        // Back-to-back: load held high, second word taken on the done edge.
        d_in[0] = 8'h3C;
        ld[0]   = 1'b1;
        tick();
        tick();
        d_in[0] = 8'hC3;
        repeat (8) tick();
        ld[0]   = 1'b0;
        repeat (12) tick();

        // Reset during cycle 4 of a word, then a clean word.
        send(0, 8'hFF);
        repeat (3) tick();
        pulse_reset();
        send(0, 8'h01);
        repeat (12) tick();

        // Same on the slow instance.
        send(1, 8'hFF);
        repeat (5) tick();
        pulse_reset();
        send(1, 8'h01);
        repeat (28) tick();

        // Random loads, data and occasional resets on both instances.
        repeat (800) begin
            for (int i = 0; i < 2; i++) begin
                ld[i]   = ($urandom_range(0, 3) == 0);
                d_in[i] = 8'($urandom);
            end
            if ($urandom_range(0, 199) == 0)
                pulse_reset();
            else
                tick();
        end

        ld[0] = 1'b0;
        ld[1] = 1'b0;
        repeat (40) tick();
        end_req = 1'b1;
        repeat (2) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
